// File: rtl/map_fill_engine.sv
// Tile-map rectangle fill engine and arbiter for map_ram port b.
// CPU map accesses always own the port; the engine writes only in cycles the CPU leaves free.
module map_fill_engine (
   input  logic        clock,
   input  logic        reset,
   input  logic        cs,
   input  logic        map_cs,
   input  logic        read,
   input  logic        write,
   input  logic [9:0]  address,
   input  logic [31:0] data_in,
   output logic [31:0] data_out,
   output logic        busy,
   output logic        b_cs,
   output logic        b_read,
   output logic        b_write,
   output logic [4:0]  b_row_index,
   output logic [4:0]  b_col_index,
   output logic [7:0]  b_in
);

   typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_FILL = 1'b1} state_t;

   state_t      state_q, state_d;
   logic [4:0]  row0_q, row0_d, col0_q, col0_d;
   logic [4:0]  hm1_q, hm1_d, wm1_q, wm1_d;
   logic [7:0]  fill_q, fill_d, step_q, step_d;
   logic [4:0]  r_q, r_d, c_q, c_d;
   logic [7:0]  tile_q, tile_d;
   logic        done_q, done_d;

   logic [1:0]  offset_s;
   logic        ctrl_wr_s, start_s, abort_s, stat_rd_s, busy_s, eng_wr_s, last_s;

   assign offset_s  = address[1:0];
   assign ctrl_wr_s = cs & write & (offset_s == 2'd0);
   // ABORT takes priority over START when both bits are written together.
   assign start_s   = ctrl_wr_s & data_in[0] & ~data_in[1];
   assign abort_s   = ctrl_wr_s & data_in[1];
   assign stat_rd_s = cs & read & (offset_s == 2'd0);
   assign busy_s    = (state_q == ST_FILL);
   assign eng_wr_s  = busy_s & ~map_cs & ~abort_s;
   assign last_s    = eng_wr_s & (r_q == hm1_q) & (c_q == wm1_q);
   assign busy      = busy_s;

   // State and register storage with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ST_IDLE;
         row0_q  <= 5'd0;
         col0_q  <= 5'd0;
         hm1_q   <= 5'd0;
         wm1_q   <= 5'd0;
         fill_q  <= 8'd0;
         step_q  <= 8'd0;
         r_q     <= 5'd0;
         c_q     <= 5'd0;
         tile_q  <= 8'd0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         row0_q  <= row0_d;
         col0_q  <= col0_d;
         hm1_q   <= hm1_d;
         wm1_q   <= wm1_d;
         fill_q  <= fill_d;
         step_q  <= step_d;
         r_q     <= r_d;
         c_q     <= c_d;
         tile_q  <= tile_d;
         done_q  <= done_d;
      end
   end

   // Configuration registers, write-protected while a fill runs.
   always_comb begin
      row0_d = row0_q;
      col0_d = col0_q;
      hm1_d  = hm1_q;
      wm1_d  = wm1_q;
      fill_d = fill_q;
      step_d = step_q;
      if (cs & write & ~busy_s) begin
         case (offset_s)
            2'd1: begin
               row0_d = data_in[12:8];
               col0_d = data_in[4:0];
            end
            2'd2: begin
               hm1_d = data_in[12:8];
               wm1_d = data_in[4:0];
            end
            2'd3: begin
               fill_d = data_in[7:0];
               step_d = data_in[15:8];
            end
            default: begin
               row0_d = row0_q;
            end
         endcase
      end else begin
         fill_d = fill_q;
      end
   end

   // Fill sequencing: counters and tile advance only on granted cycles.
   always_comb begin
      state_d = state_q;
      r_d     = r_q;
      c_d     = c_q;
      tile_d  = tile_q;
      case (state_q)
         ST_IDLE: begin
            if (start_s) begin
               state_d = ST_FILL;
               r_d     = 5'd0;
               c_d     = 5'd0;
               tile_d  = fill_q;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_FILL: begin
            if (abort_s) begin
               state_d = ST_IDLE;
            end else if (eng_wr_s) begin
               tile_d = tile_q + step_q;
               if (c_q == wm1_q) begin
                  c_d = 5'd0;
                  r_d = r_q + 5'd1;
               end else begin
                  c_d = c_q + 5'd1;
               end
               if (last_s) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_FILL;
               end
            end else begin
               state_d = ST_FILL;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // DONE is sticky; setting it beats a status-read clear on the same edge.
   always_comb begin
      done_d = done_q;
      if (last_s) begin
         done_d = 1'b1;
      end else if (start_s & ~busy_s) begin
         done_d = 1'b0;
      end else if (stat_rd_s) begin
         done_d = 1'b0;
      end else begin
         done_d = done_q;
      end
   end

   // Port-b arbitration: CPU passthrough first, then the engine.
   always_comb begin
      b_cs        = 1'b0;
      b_read      = 1'b0;
      b_write     = 1'b0;
      b_row_index = 5'd0;
      b_col_index = 5'd0;
      b_in        = 8'd0;
      if (map_cs) begin
         b_cs        = 1'b1;
         b_read      = read;
         b_write     = write;
         b_row_index = address[9:5];
         b_col_index = address[4:0];
         b_in        = data_in[31:24];
      end else if (eng_wr_s) begin
         b_cs        = 1'b1;
         b_write     = 1'b1;
         b_row_index = row0_q + r_q;
         b_col_index = col0_q + c_q;
         b_in        = tile_q;
      end else begin
         b_cs = 1'b0;
      end
   end

   // Register read-back mux.
   always_comb begin
      data_out = 32'd0;
      if (cs & read) begin
         case (offset_s)
            2'd0:    data_out = {30'd0, done_q, busy_s};
            2'd1:    data_out = {19'd0, row0_q, 3'd0, col0_q};
            2'd2:    data_out = {19'd0, hm1_q, 3'd0, wm1_q};
            2'd3:    data_out = {16'd0, step_q, fill_q};
            default: data_out = 32'd0;
         endcase
      end else begin
         data_out = 32'd0;
      end
   end

endmodule

// File: tb/tb_map_fill_engine.sv
// Directed and randomized checks of map_fill_engine against a rectangle-list model.
module tb_map_fill_engine;

   logic        clock = 1'b0;
   logic        reset, cs, map_cs, read, write;
   logic [9:0]  address;
   logic [31:0] data_in, data_out;
   logic        busy, b_cs, b_read, b_write;
   logic [4:0]  b_row_index, b_col_index;
   logic [7:0]  b_in;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [4:0] r;
      logic [4:0] c;
      logic [7:0] t;
   } wr_t;
   wr_t exp_q[$];

   map_fill_engine dut (
      .clock(clock), .reset(reset), .cs(cs), .map_cs(map_cs), .read(read),
      .write(write), .address(address), .data_in(data_in), .data_out(data_out),
      .busy(busy), .b_cs(b_cs), .b_read(b_read), .b_write(b_write),
      .b_row_index(b_row_index), .b_col_index(b_col_index), .b_in(b_in)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_bus();
      cs = 1'b0; map_cs = 1'b0; read = 1'b0; write = 1'b0;
      address = 10'd0; data_in = 32'd0;
   endtask

   task automatic reg_write(input logic [1:0] off, input logic [31:0] val);
      cs = 1'b1; write = 1'b1; address = {8'd0, off}; data_in = val;
      cyc();
      idle_bus();
   endtask

   task automatic reg_read(input string tag, input logic [1:0] off, input logic [31:0] exp);
      cs = 1'b1; read = 1'b1; address = {8'd0, off};
      #3;
      chk(tag, data_out, exp);
      cyc();
      idle_bus();
   endtask

   // Programs and starts a fill, then follows it cycle by cycle against the expected write list.
   task automatic run_fill(input string tag, input int r0, input int c0, input int w, input int h,
                           input int fill, input int step, input int stall_a, input int stall_b,
                           input int abort_after, input int poke_at, input bit rd_last);
      int n = 0, writes = 0, stalls = 0;
      bit aborted = 1'b0;
      wr_t e;
      logic [9:0]  ca;
      logic [31:0] cd;
      exp_q.delete();
      for (int r = 0; r < h; r++)
         for (int c = 0; c < w; c++)
            exp_q.push_back('{r: 5'((r0 + r) % 32), c: 5'((c0 + c) % 32),
                              t: 8'((fill + step * (r * w + c)) % 256)});
      reg_write(2'd1, 32'((r0 << 8) | c0));
      reg_write(2'd2, 32'(((h - 1) << 8) | (w - 1)));
      reg_write(2'd3, 32'((step << 8) | fill));
      reg_write(2'd0, 32'd1);
      while (exp_q.size() > 0 && !aborted && n < w * h + 8) begin
         n++;
         if (n == stall_a || n == stall_b) begin
            ca = 10'($urandom); cd = $urandom;
            map_cs = 1'b1; write = 1'b1; address = ca; data_in = cd;
            #3;
            chk({tag, "_cpu_pass"}, {b_cs, b_read, b_write, b_row_index, b_col_index, b_in},
                {1'b1, 1'b0, 1'b1, ca[9:5], ca[4:0], cd[31:24]});
            stalls++;
            cyc();
            idle_bus();
         end else if (abort_after >= 0 && writes == abort_after) begin
            cs = 1'b1; write = 1'b1; address = 10'd0; data_in = 32'd2;
            #3;
            chk({tag, "_abort_nowrite"}, b_write, 1'b0);
            aborted = 1'b1;
            cyc();
            idle_bus();
         end else begin
            if (poke_at > 0 && n == poke_at) begin
               cs = 1'b1; write = 1'b1; address = 10'd1; data_in = 32'h0505;
            end else if (poke_at > 0 && n == poke_at + 1) begin
               cs = 1'b1; write = 1'b1; address = 10'd0; data_in = 32'd1;
            end else if (rd_last && exp_q.size() == 1) begin
               cs = 1'b1; read = 1'b1; address = 10'd0;
            end
            #3;
            e = exp_q.pop_front();
            chk({tag, "_eng_wr"}, {busy, b_cs, b_read, b_write, b_row_index, b_col_index, b_in},
                {1'b1, 1'b1, 1'b0, 1'b1, e.r, e.c, e.t});
            writes++;
            cyc();
            idle_bus();
         end
      end
      #3;
      chk({tag, "_busy_end"}, busy, 1'b0);
      if (aborted) begin
         chk({tag, "_abort_count"}, writes, abort_after);
      end else begin
         chk({tag, "_drained"}, exp_q.size(), 0);
         chk({tag, "_cycles"}, n, w * h + stalls);
      end
      cyc();
   endtask

   initial begin
      idle_bus();
      reset = 1'b1;
      cyc(); cyc();
      reset = 1'b0;
      #3;
      chk("rst_busy", busy, 1'b0);
      chk("rst_bcs", b_cs, 1'b0);
      cyc();
      for (int k = 0; k < 4; k++) reg_read("rst_reg", 2'(k), 32'd0);

      run_fill("basic", 2, 3, 3, 2, 5, 1, 0, 0, -1, 0, 1'b0);
      reg_read("basic_stat1", 2'd0, 32'd2);
      reg_read("basic_stat2", 2'd0, 32'd0);

      run_fill("wrap", 31, 31, 2, 2, 8'h2A, 0, 0, 0, -1, 0, 1'b0);
      reg_read("wrap_stat", 2'd0, 32'd2);

      run_fill("stall", 10, 20, 4, 4, 8'hF0, 3, 2, 5, -1, 0, 1'b1);
      reg_read("stall_stat_setwins", 2'd0, 32'd2);

      run_fill("abort", 0, 0, 32, 32, 8'h11, 1, 0, 0, 10, 0, 1'b0);
      reg_read("abort_stat", 2'd0, 32'd0);
      reg_write(2'd2, 32'h0303);
      reg_read("abort_size_wr", 2'd2, 32'h0303);

      run_fill("prot", 7, 9, 3, 3, 8'h40, 2, 0, 0, -1, 8, 1'b0);
      reg_read("prot_origin", 2'd1, 32'h0709);
      reg_read("prot_stat", 2'd0, 32'd2);

      for (int k = 0; k < 6; k++) begin
         int w, h;
         w = $urandom_range(1, 6);
         h = $urandom_range(1, 6);
         run_fill("rand", $urandom_range(0, 31), $urandom_range(0, 31), w, h,
                  $urandom_range(0, 255), $urandom_range(0, 255),
                  $urandom_range(1, w * h), $urandom_range(1, w * h), -1, 0, 1'b0);
         reg_read("rand_tile", 2'd0, 32'd2);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/map_fill_engine.md
# map_fill_engine

Tile-map fill controller and port-b arbiter for `map_ram`. It sits between the CPU bus and `map_ram` port b. It passes CPU map accesses straight through and, when the CPU starts it, autonomously writes a rectangle of tile indices into the 32x32 map. CPU accesses always win the port; the engine stalls for that cycle and retries.

## Interface

Parameters: none.

Ports:
- `clock`  in  1  CPU clock; also clocks `map_ram` port b
- `reset`  in  1  synchronous, active-high
- `cs`  in  1  engine register window select (from the address decoder)
- `map_cs`  in  1  CPU map-RAM window select
- `read`  in  1  CPU bus read strobe
- `write`  in  1  CPU bus write strobe
- `address`  in  10  CPU `address[11:2]`; `[11:7]` = map row, `[6:2]` = map col; `[3:2]` = register offset when `cs`
- `data_in`  in  32  CPU write data
- `data_out`  out  32  register read data; 0 when `cs` is low
- `busy`  out  1  fill in progress
- `b_cs`  out  1  to `map_ram.b_cs`
- `b_read`  out  1  to `map_ram.b_read`
- `b_write`  out  1  to `map_ram.b_write`
- `b_row_index`  out  5  to `map_ram.b_row_index`
- `b_col_index`  out  5  to `map_ram.b_col_index`
- `b_in`  out  8  to `map_ram.b_in`

## Operation

Registers (offset = `address[3:2]`, written on the clock edge with `cs & write`):
- 0 CTRL/STATUS
  - write: bit0 START, bit1 ABORT.
  - read: bit0 `busy`, bit1 DONE (sticky); other bits 0.
- 1 ORIGIN: `[12:8]` row0, `[4:0]` col0.
- 2 SIZE: `[12:8]` H-1, `[4:0]` W-1. The field value is one less than the count, so 1..32 each.
- 3 TILE: `[7:0]` fill value, `[15:8]` step.

Register rules:
- All registers reset to 0.
- Writes to offsets 1–3 are ignored while `busy`.
- Reading offset 0 (`cs & read`) clears DONE at that edge.

State machine: IDLE, FILL.
- IDLE -> FILL on START when not busy.
  - At that edge: load row/col counters to 0, load the working tile from TILE[7:0], clear DONE.
  - START while busy is ignored.
- FILL, granted cycle (`map_cs` low):
  - Write the working tile to map (row0+r, col0+c).
  - Then `tile += step`, mod 256.
  - c advances. When c == W-1, c returns to 0 and r advances.
  - After the write at r == H-1, c == W-1: go to IDLE and set DONE.
- FILL, stalled cycle (`map_cs` high): no engine write and no counter or tile change.
- ABORT in FILL: go to IDLE at that edge. DONE is not set, and no engine write happens that cycle. ABORT wins over START in the same write.

Address arithmetic:
- row0+r and col0+c are 5-bit adds, wrapping modulo 32.
- A rectangle crossing the map edge wraps to row/col 0.

Port-b mux (combinational):
- When `map_cs` is high: `b_cs=1`, `b_read=read`, `b_write=write`, `b_row_index=address[11:7]`, `b_col_index=address[6:2]`, `b_in=data_in[31:24]`.
- Else in FILL: `b_cs=1`, `b_read=0`, `b_write=1`, engine row/col/tile.
- Else: all outputs 0.

## Timing

- Reset values: `busy=0`, `data_out=0`. All `b_*` outputs follow the mux, so they are 0 when `map_cs` is low. DONE=0, state IDLE.
- A reset asserted mid-fill returns the engine to IDLE next edge. Partial writes stay in map RAM.
- `data_out` is combinational from `cs`, `read` and `address[3:2]`. It is valid in the same cycle.
- Latency:
  - START written at edge N. `busy` is high after N, and the first engine write is presented in cycle N+1 and committed at edge N+1.
  - An uncontended W×H fill takes W*H cycles.
  - `busy` falls, and DONE sets, at the edge that commits the last write.
- Each stalled cycle adds exactly one cycle.
- CPU map reads during FILL return correct data with CPU-only timing. The engine never corrupts a CPU access.
- Simultaneous events:
  - CPU map write during a fill cycle: the CPU write lands and the engine write is deferred.
  - START and register write-protect: a START written in the same cycle as the fill ends (last-write edge) is ignored.
  - DONE clear vs. set: a status read on the same edge that DONE sets leaves DONE=1 (set wins).

## Test plan

- Reset, then read offsets 0–3 -> all 0; `busy`=0; `b_cs`=0.
- ORIGIN=0x0203, SIZE=0x0102 (3 wide, 2 high), TILE=0x0105, START -> six consecutive `b_write` cycles:
  - (2,3)=05, (2,4)=06, (2,5)=07, (3,3)=08, (3,4)=09, (3,5)=0A.
  - `busy` drops after cycle 6, and a STATUS read returns 2 then 0.
- ORIGIN=0x1F1F, SIZE=0x0101, step 0, fill 0x2A -> writes (31,31), (31,0), (0,31), (0,0), all 0x2A.
- 4x4 fill with CPU `map_cs` writes in fill cycles 2 and 5 -> CPU data lands at the CPU addresses; engine writes complete in 18 cycles with no tile skipped or duplicated.
- Start a 32x32 fill, write ABORT at cycle 10 -> `busy` low next edge, exactly 10 engine writes, DONE=0; a SIZE write now takes effect.
- While busy, write ORIGIN and a second START -> ignored; fill completes with the original ORIGIN.
